// File: rtl/decode_stage_pipe.sv
// Pipelined MIPS decode stage: register file, immediate extension, load-use hazard bubble, ID/EX register.
// Optional feature: define DECODE_WB_BYPASS_EN for write-first bypass of same-cycle WB writes into operands.
module decode_stage_pipe #(
  parameter int NBITS = 32,
  parameter int NREGS = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [NBITS-1:0] i_pc,
  input  logic [31:0]      i_instruction,
  input  logic             i_ex_stall,
  input  logic             i_flush,
  input  logic             i_wr_en,
  input  logic [4:0]       i_rd_sel,
  input  logic [NBITS-1:0] i_wr_data,
  output logic             o_stall_if,
  output logic             o_valid,
  output logic [NBITS-1:0] o_pc,
  output logic [NBITS-1:0] o_rs_data,
  output logic [NBITS-1:0] o_rt_data,
  output logic [NBITS-1:0] o_imm_ext,
  output logic [4:0]       o_rs,
  output logic [4:0]       o_rt,
  output logic [4:0]       o_rd,
  output logic [4:0]       o_sa,
  output logic [5:0]       o_opcode,
  output logic [5:0]       o_funct,
  output logic             o_mem_rd,
  output logic             o_mem_wr
);

  localparam int RW = $clog2(NREGS);

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sa;
  logic [5:0]  funct;
  logic [15:0] imm;

  assign opcode = i_instruction[31:26];
  assign rs     = i_instruction[25:21];
  assign rt     = i_instruction[20:16];
  assign rd     = i_instruction[15:11];
  assign sa     = i_instruction[10:6];
  assign funct  = i_instruction[5:0];
  assign imm    = i_instruction[15:0];

  logic [RW-1:0] rs_idx;
  logic [RW-1:0] rt_idx;
  logic [RW-1:0] wr_idx;
  logic          wr_hit;

  assign rs_idx = rs[RW-1:0];
  assign rt_idx = rt[RW-1:0];
  assign wr_idx = i_rd_sel[RW-1:0];
  // Index check rather than full field so aliased selects for small NREGS never hit r0.
  assign wr_hit = i_wr_en && (i_rd_sel != 5'd0) && (wr_idx != '0);

  logic [NBITS-1:0] regs [NREGS];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int k = 0; k < NREGS; k++) regs[k] <= '0;
    end else if (wr_hit) begin
      regs[wr_idx] <= i_wr_data;
    end
  end

  logic [NBITS-1:0] rs_data;
  logic [NBITS-1:0] rt_data;

  always_comb begin
    rs_data = (rs_idx == '0) ? '0 : regs[rs_idx];
    rt_data = (rt_idx == '0) ? '0 : regs[rt_idx];
`ifdef DECODE_WB_BYPASS_EN
    if (wr_hit && (wr_idx == rs_idx)) rs_data = i_wr_data;
    if (wr_hit && (wr_idx == rt_idx)) rt_data = i_wr_data;
`else
    // Pre-write contents are returned; the compiler keeps WB-to-ID dependencies one cycle apart.
`endif
  end

  logic [NBITS-1:0] imm_ext;
  logic             zero_ext;
  logic             mem_rd;
  logic             mem_wr;

  assign zero_ext = (opcode == 6'h0C) || (opcode == 6'h0D) || (opcode == 6'h0E);
  assign imm_ext  = zero_ext ? {{(NBITS-16){1'b0}}, imm} : {{(NBITS-16){imm[15]}}, imm};
  assign mem_rd   = (opcode[5:3] == 3'b100);
  assign mem_wr   = (opcode[5:3] == 3'b101);

  logic valid_q;
  logic mem_rd_q;
  logic mem_wr_q;
  logic hz;

  // Flags are gated by valid so a bubble can never look like a load.
  assign o_valid  = valid_q;
  assign o_mem_rd = valid_q & mem_rd_q;
  assign o_mem_wr = valid_q & mem_wr_q;

  // rt is compared even for instructions that only read rs: conservative by design.
  assign hz = o_valid && o_mem_rd && (o_rt != 5'd0) && i_valid &&
              ((rs == o_rt) || (rt == o_rt));

  assign o_stall_if = i_rst & (hz | i_ex_stall) & ~i_flush;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      valid_q   <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      o_pc      <= '0;
      o_rs_data <= '0;
      o_rt_data <= '0;
      o_imm_ext <= '0;
      o_rs      <= '0;
      o_rt      <= '0;
      o_rd      <= '0;
      o_sa      <= '0;
      o_opcode  <= '0;
      o_funct   <= '0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
    end else if (i_ex_stall) begin
      valid_q <= valid_q;
    end else if (hz) begin
      valid_q <= 1'b0;
    end else begin
      valid_q   <= i_valid;
      mem_rd_q  <= mem_rd;
      mem_wr_q  <= mem_wr;
      o_pc      <= i_pc;
      o_rs_data <= rs_data;
      o_rt_data <= rt_data;
      o_imm_ext <= imm_ext;
      o_rs      <= rs;
      o_rt      <= rt;
      o_rd      <= rd;
      o_sa      <= sa;
      o_opcode  <= opcode;
      o_funct   <= funct;
    end
  end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed self-checking bench for decode_stage_pipe.
module tb_decode_stage_pipe;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        ex_stall;
  logic        flush;
  logic        wr_en;
  logic [4:0]  rd_sel;
  logic [31:0] wr_data;
  logic        stall_if;
  logic        o_valid;
  logic [31:0] o_pc, o_rs_data, o_rt_data, o_imm_ext;
  logic [4:0]  o_rs, o_rt, o_rd, o_sa;
  logic [5:0]  o_opcode, o_funct;
  logic        o_mem_rd, o_mem_wr;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] ADD_R5   = 32'h00A00020; // add r0,r5,r0
  localparam logic [31:0] ANDI     = 32'h30028001; // andi r2,r0,0x8001
  localparam logic [31:0] LW_R4    = 32'h8C048001; // lw r4,0x8001(r0)
  localparam logic [31:0] SW_R4    = 32'hAC240008; // sw r4,8(r1)
  localparam logic [31:0] LW_R8    = 32'h8C280004; // lw r8,4(r1)
  localparam logic [31:0] ADD_R9   = 32'h01014820; // add r9,r8,r1
  localparam logic [31:0] LW_R0    = 32'h8C200004; // lw r0,4(r1)
  localparam logic [31:0] ADD_USE0 = 32'h00004820; // add r9,r0,r0
  localparam logic [31:0] ADD_R3   = 32'h00600020; // add r0,r3,r0

  decode_stage_pipe #(.NBITS(32), .NREGS(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_pc(pc), .i_instruction(instr),
    .i_ex_stall(ex_stall), .i_flush(flush), .i_wr_en(wr_en), .i_rd_sel(rd_sel),
    .i_wr_data(wr_data), .o_stall_if(stall_if), .o_valid(o_valid), .o_pc(o_pc),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm_ext(o_imm_ext),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_sa(o_sa), .o_opcode(o_opcode),
    .o_funct(o_funct), .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p);
    valid = v;
    instr = ins;
    pc    = p;
  endtask

  task automatic test_reset();
    rst = 1'b0; valid = 1'b1; pc = 32'h10; instr = LW_R8; ex_stall = 1'b1; flush = 1'b0;
    wr_en = 1'b0; rd_sel = 5'd0; wr_data = 32'h0;
    tick(); tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", o_valid); end
    checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", o_pc); end
    checks++; if (o_opcode !== 6'h0) begin errors++; $display("FAIL reset_opcode got %h exp 0", o_opcode); end
    checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL reset_stall_if got %h exp 0", stall_if); end
    ex_stall = 1'b0; valid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_write_read();
    drive(1'b0, 32'h0, 32'h0);
    wr_en = 1'b1; rd_sel = 5'd5; wr_data = 32'h1234;
    tick();
    wr_en = 1'b0;
    drive(1'b1, ADD_R5, 32'h100);
    tick();
    checks++; if (o_rs_data !== 32'h1234) begin errors++; $display("FAIL wr_rd_rs_data got %h exp 00001234", o_rs_data); end
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL wr_rd_valid got %h exp 1", o_valid); end
    checks++; if (o_pc !== 32'h100) begin errors++; $display("FAIL wr_rd_pc got %h exp 100", o_pc); end
    checks++; if (o_rs !== 5'd5 || o_funct !== 6'h20) begin errors++; $display("FAIL wr_rd_fields got rs=%h funct=%h exp 05/20", o_rs, o_funct); end
  endtask

  task automatic test_zero_reg_imm();
    drive(1'b0, 32'h0, 32'h0);
    wr_en = 1'b1; rd_sel = 5'd0; wr_data = 32'hFFFF_FFFF;
    tick();
    wr_en = 1'b0;
    drive(1'b1, ANDI, 32'h110);
    tick();
    checks++; if (o_rs_data !== 32'h0) begin errors++; $display("FAIL zero_reg got %h exp 0", o_rs_data); end
    checks++; if (o_imm_ext !== 32'h0000_8001) begin errors++; $display("FAIL andi_zext got %h exp 00008001", o_imm_ext); end
    checks++; if (o_opcode !== 6'h0C || o_rt !== 5'd2) begin errors++; $display("FAIL andi_fields got op=%h rt=%h exp 0c/02", o_opcode, o_rt); end
    drive(1'b1, SW_R4, 32'h114);
    tick();
    checks++; if (o_mem_wr !== 1'b1 || o_mem_rd !== 1'b0) begin errors++; $display("FAIL sw_flags got wr=%h rd=%h exp 1/0", o_mem_wr, o_mem_rd); end
    checks++; if (o_imm_ext !== 32'h8) begin errors++; $display("FAIL sw_imm got %h exp 8", o_imm_ext); end
    drive(1'b1, LW_R4, 32'h118);
    tick();
    checks++; if (o_imm_ext !== 32'hFFFF_8001) begin errors++; $display("FAIL lw_sext got %h exp ffff8001", o_imm_ext); end
    checks++; if (o_mem_rd !== 1'b1) begin errors++; $display("FAIL lw_mem_rd got %h exp 1", o_mem_rd); end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    checks++; if (o_mem_rd !== 1'b0 || o_valid !== 1'b0) begin errors++; $display("FAIL idle_mem_rd got rd=%h v=%h exp 0/0", o_mem_rd, o_valid); end
  endtask

  task automatic test_load_use();
    drive(1'b1, LW_R8, 32'h200);
    tick();
    drive(1'b1, ADD_R9, 32'h204);
    #1;
    checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL lu_stall got %h exp 1", stall_if); end
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %h exp 0", o_valid); end
    checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL lu_stall_release got %h exp 0", stall_if); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h204 || o_rd !== 5'd9) begin errors++; $display("FAIL lu_dep got v=%h pc=%h rd=%h exp 1/204/09", o_valid, o_pc, o_rd); end
    drive(1'b1, LW_R0, 32'h208);
    tick();
    drive(1'b1, ADD_USE0, 32'h20C);
    #1;
    checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL lu_r0_stall got %h exp 0", stall_if); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h20C) begin errors++; $display("FAIL lu_r0_pass got v=%h pc=%h exp 1/20c", o_valid, o_pc); end
  endtask

  task automatic test_flush_hazard();
    drive(1'b1, LW_R8, 32'h240);
    tick();
    drive(1'b1, ADD_R9, 32'h244);
    flush = 1'b1;
    #1;
    checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL flush_stall got %h exp 0", stall_if); end
    tick();
    checks++; if (o_valid !== 1'b0 || o_mem_rd !== 1'b0) begin errors++; $display("FAIL flush_valid got v=%h rd=%h exp 0/0", o_valid, o_mem_rd); end
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_ex_stall();
    drive(1'b1, ANDI, 32'h300);
    tick();
    ex_stall = 1'b1;
    drive(1'b1, SW_R4, 32'h304);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL exs_stall_if[%0d] got %h exp 1", i, stall_if); end
      tick();
      checks++; if (o_pc !== 32'h300 || o_opcode !== 6'h0C || o_valid !== 1'b1) begin errors++; $display("FAIL exs_hold[%0d] got pc=%h op=%h v=%h exp 300/0c/1", i, o_pc, o_opcode, o_valid); end
    end
    ex_stall = 1'b0;
    tick();
    checks++; if (o_pc !== 32'h304 || o_mem_wr !== 1'b1) begin errors++; $display("FAIL exs_resume got pc=%h wr=%h exp 304/1", o_pc, o_mem_wr); end
    drive(1'b1, LW_R8, 32'h308);
    tick();
    drive(1'b1, ADD_R9, 32'h30C);
    ex_stall = 1'b1;
    #1;
    checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL exs_hz_stall got %h exp 1", stall_if); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h308 || o_mem_rd !== 1'b1) begin errors++; $display("FAIL exs_hz_hold got v=%h pc=%h rd=%h exp 1/308/1", o_valid, o_pc, o_mem_rd); end
    ex_stall = 1'b0;
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL exs_hz_bubble got %h exp 0", o_valid); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h30C) begin errors++; $display("FAIL exs_hz_dep got v=%h pc=%h exp 1/30c", o_valid, o_pc); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_rs;
`ifdef DECODE_WB_BYPASS_EN
    exp_rs = 32'h0000_CAFE;
`else
    exp_rs = 32'h0000_1111;
`endif
    drive(1'b0, 32'h0, 32'h0);
    wr_en = 1'b1; rd_sel = 5'd3; wr_data = 32'h1111;
    tick();
    wr_data = 32'hCAFE;
    drive(1'b1, ADD_R3, 32'h400);
    tick();
    checks++; if (o_rs_data !== exp_rs) begin errors++; $display("FAIL bypass_same_cycle got %h exp %h", o_rs_data, exp_rs); end
    wr_en = 1'b0;
    tick();
    checks++; if (o_rs_data !== 32'hCAFE) begin errors++; $display("FAIL bypass_next_cycle got %h exp 0000cafe", o_rs_data); end
  endtask

  task automatic test_async_reset();
    #3;
    rst = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0 || o_pc !== 32'h0) begin errors++; $display("FAIL areset_ctl got v=%h pc=%h exp 0/0", o_valid, o_pc); end
    checks++; if (o_rs_data !== 32'h0 || o_funct !== 6'h0) begin errors++; $display("FAIL areset_data got rs=%h funct=%h exp 0/0", o_rs_data, o_funct); end
    #2;
    rst = 1'b1;
    tick();
    checks++; if (o_valid !== 1'b1 || o_rs_data !== 32'h0) begin errors++; $display("FAIL areset_rf_cleared got v=%h rs=%h exp 1/0", o_valid, o_rs_data); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg_imm();
    test_load_use();
    test_flush_hazard();
    test_ex_stall();
    test_bypass();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
